// File: rtl/exarbiter_if.sv
// Word-stream bundle between the two sources, the arbiter and the downstream stage.
// slave = arbiter side, master = the surrounding logic that drives sources and sink.
interface exarbiter_if;
  logic        i_a_stb;
  logic [34:0] i_a_word;
  logic        i_a_last;
  logic        o_a_busy;
  logic        i_b_stb;
  logic [34:0] i_b_word;
  logic        i_b_last;
  logic        o_b_busy;
  logic        o_stb;
  logic [34:0] o_word;
  logic        o_last;
  logic        i_busy;
  logic [1:0]  o_grant;
  logic        o_stall_err;

  modport slave (
    input  i_a_stb, i_a_word, i_a_last, i_b_stb, i_b_word, i_b_last, i_busy,
    output o_a_busy, o_b_busy, o_stb, o_word, o_last, o_grant, o_stall_err
  );

  modport master (
    output i_a_stb, i_a_word, i_a_last, i_b_stb, i_b_word, i_b_last, i_busy,
    input  o_a_busy, o_b_busy, o_stb, o_word, o_last, o_grant, o_stall_err
  );
endinterface

// File: rtl/exarbiter.sv
// Two-source packet-atomic arbiter for the exbus word stream, with a registered
// output stage and a watchdog that drops a lock whose owner stops sending.
module exarbiter #(
  parameter logic OPT_ROUNDROBIN = 1'b1,
  parameter int   LGSTALL        = 10,
  parameter logic OPT_LOWPOWER   = 1'b0
) (
  input logic        i_clk,
  input logic        i_reset_n,
  exarbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOCK_A = 2'd1;
  localparam logic [1:0] S_LOCK_B = 2'd2;
  // Last count before all-ones: the release lands on the edge the counter would hit it.
  localparam logic [LGSTALL-1:0] CNT_FIRE = LGSTALL'((1 << LGSTALL) - 2);

  logic [1:0]         state_q, state_d;
  logic               rr_q, rr_d;           // 0 = A preferred, 1 = B preferred
  logic [LGSTALL-1:0] cnt_q, cnt_d;
  logic               stall_q, stall_d;
  logic               o_stb_q, o_stb_d;
  logic [34:0]        o_word_q, o_word_d;
  logic               o_last_q, o_last_d;

  logic out_free, idle, sel_a, sel_b, a_ok, b_ok, a_xfer, b_xfer;

  always_comb begin
    out_free = !o_stb_q || !bus.i_busy;
    idle     = (state_q == S_IDLE);
    sel_a    = bus.i_a_stb && (!bus.i_b_stb || !OPT_ROUNDROBIN || !rr_q);
    sel_b    = bus.i_b_stb && !sel_a;
    a_ok     = out_free && ((idle && sel_a) || (state_q == S_LOCK_A));
    b_ok     = out_free && ((idle && sel_b) || (state_q == S_LOCK_B));
    a_xfer   = bus.i_a_stb && a_ok;
    b_xfer   = bus.i_b_stb && b_ok;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = '0;
    stall_d = 1'b0;
    if (a_xfer) begin
      if (bus.i_a_last) begin
        state_d = S_IDLE;
        rr_d    = 1'b1;
      end else begin
        state_d = S_LOCK_A;
      end
    end else if (b_xfer) begin
      if (bus.i_b_last) begin
        state_d = S_IDLE;
        rr_d    = 1'b0;
      end else begin
        state_d = S_LOCK_B;
      end
    end else if (!idle) begin
      if (cnt_q == CNT_FIRE) begin
        state_d = S_IDLE;
        rr_d    = (state_q == S_LOCK_A);
        stall_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    o_stb_d  = o_stb_q;
    o_word_d = o_word_q;
    o_last_d = o_last_q;
    if (a_xfer) begin
      o_stb_d  = 1'b1;
      o_word_d = bus.i_a_word;
      o_last_d = bus.i_a_last;
    end else if (b_xfer) begin
      o_stb_d  = 1'b1;
      o_word_d = bus.i_b_word;
      o_last_d = bus.i_b_last;
    end else if (!bus.i_busy) begin
      o_stb_d = 1'b0;
      if (OPT_LOWPOWER) begin
        o_word_d = '0;
        o_last_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      stall_q  <= 1'b0;
      o_stb_q  <= 1'b0;
      o_word_q <= '0;
      o_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      o_stb_q  <= o_stb_d;
      o_word_q <= o_word_d;
      o_last_q <= o_last_d;
    end
  end

  assign bus.o_a_busy    = !a_ok;
  assign bus.o_b_busy    = !b_ok;
  assign bus.o_stb       = o_stb_q;
  assign bus.o_word      = o_word_q;
  assign bus.o_last      = o_last_q;
  assign bus.o_grant     = {state_q == S_LOCK_B, state_q == S_LOCK_A};
  assign bus.o_stall_err = stall_q;

endmodule

// File: tb/tb_exarbiter.sv
// Directed bench: a round-robin arbiter with a short watchdog, plus a fixed-priority
// twin fed the same stimulus for the priority comparison.
module tb_exarbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  exarbiter_if bus();
  exarbiter_if bus0();

  exarbiter #(.OPT_ROUNDROBIN(1'b1), .LGSTALL(4), .OPT_LOWPOWER(1'b0)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus.slave)
  );
  exarbiter #(.OPT_ROUNDROBIN(1'b0), .LGSTALL(4), .OPT_LOWPOWER(1'b0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus0.slave)
  );

  assign bus0.i_a_stb  = bus.i_a_stb;
  assign bus0.i_a_word = bus.i_a_word;
  assign bus0.i_a_last = bus.i_a_last;
  assign bus0.i_b_stb  = bus.i_b_stb;
  assign bus0.i_b_word = bus.i_b_word;
  assign bus0.i_b_last = bus.i_b_last;
  assign bus0.i_busy   = bus.i_busy;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic stb, input logic [34:0] w, input logic last);
    bus.i_a_stb = stb; bus.i_a_word = w; bus.i_a_last = last;
  endtask

  task automatic set_b(input logic stb, input logic [34:0] w, input logic last);
    bus.i_b_stb = stb; bus.i_b_word = w; bus.i_b_last = last;
  endtask

  initial begin
    logic [34:0] exp_w;
    set_a(1'b0, '0, 1'b0);
    set_b(1'b0, '0, 1'b0);
    bus.i_busy = 1'b0;

    // Reset state
    #12;
    chk("rst_stb", bus.o_stb, 1'b0);
    chk("rst_word", bus.o_word, 35'h0);
    chk("rst_last", bus.o_last, 1'b0);
    chk("rst_grant", bus.o_grant, 2'b00);
    chk("rst_stall", bus.o_stall_err, 1'b0);
    cyc();
    rst_n = 1'b1;

    // Single-word packet from A: one-cycle latency, no lock
    set_a(1'b1, 35'h1_2345_6789, 1'b1);
    #1 chk("t1_a_busy", bus.o_a_busy, 1'b0);
    cyc();
    chk("t1_stb", bus.o_stb, 1'b1);
    chk("t1_word", bus.o_word, 35'h1_2345_6789);
    chk("t1_last", bus.o_last, 1'b1);
    chk("t1_grant", bus.o_grant, 2'b00);

    // B single word brings the preference back to A
    set_a(1'b0, '0, 1'b0);
    set_b(1'b1, 35'h0_0000_0B00, 1'b1);
    #1 chk("t1b_b_busy", bus.o_b_busy, 1'b0);
    cyc();
    chk("t1b_word", bus.o_word, 35'h0_0000_0B00);

    // A 3-word packet while B requests throughout
    set_a(1'b1, 35'h0_0000_0A01, 1'b0);
    set_b(1'b1, 35'h0_0000_0B01, 1'b1);
    #1 chk("t2_b_busy0", bus.o_b_busy, 1'b1);
    chk("t2_a_busy0", bus.o_a_busy, 1'b0);
    cyc();
    chk("t2_w1", bus.o_word, 35'h0_0000_0A01);
    chk("t2_l1", bus.o_last, 1'b0);
    chk("t2_g1", bus.o_grant, 2'b01);
    set_a(1'b1, 35'h0_0000_0A02, 1'b0);
    #1 chk("t2_b_busy1", bus.o_b_busy, 1'b1);
    cyc();
    chk("t2_w2", bus.o_word, 35'h0_0000_0A02);
    chk("t2_g2", bus.o_grant, 2'b01);
    set_a(1'b1, 35'h0_0000_0A03, 1'b1);
    #1 chk("t2_b_busy2", bus.o_b_busy, 1'b1);
    cyc();
    chk("t2_w3", bus.o_word, 35'h0_0000_0A03);
    chk("t2_l3", bus.o_last, 1'b1);
    chk("t2_g3", bus.o_grant, 2'b00);
    set_a(1'b0, '0, 1'b0);
    #1 chk("t2_b_free", bus.o_b_busy, 1'b0);
    cyc();
    chk("t2_wb", bus.o_word, 35'h0_0000_0B01);
    chk("t2_g_b", bus.o_grant, 2'b00);

    // Both sources stream single words: RR alternates, fixed priority keeps A
    set_a(1'b1, 35'h0_0000_AAAA, 1'b1);
    set_b(1'b1, 35'h0_0000_BBBB, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      exp_w = (k % 2 == 0) ? 35'h0_0000_AAAA : 35'h0_0000_BBBB;
      chk($sformatf("rr_word%0d", k), bus.o_word, exp_w);
      chk($sformatf("fixed_word%0d", k), bus0.o_word, 35'h0_0000_AAAA);
    end
    set_a(1'b0, '0, 1'b0);
    set_b(1'b0, '0, 1'b0);
    cyc();
    chk("idle_stb", bus.o_stb, 1'b0);

    // Downstream stall for 5 cycles with a word held on the output
    set_a(1'b1, 35'h4_0000_0001, 1'b1);
    cyc();
    chk("st_w1", bus.o_word, 35'h4_0000_0001);
    bus.i_busy = 1'b1;
    set_a(1'b1, 35'h4_0000_0002, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("st_a_busy%0d", k), bus.o_a_busy, 1'b1);
      chk($sformatf("st_b_busy%0d", k), bus.o_b_busy, 1'b1);
      cyc();
      chk($sformatf("st_hold%0d", k), bus.o_word, 35'h4_0000_0001);
      chk($sformatf("st_stb%0d", k), bus.o_stb, 1'b1);
    end
    bus.i_busy = 1'b0;
    #1 chk("st_a_free", bus.o_a_busy, 1'b0);
    cyc();
    chk("st_w2", bus.o_word, 35'h4_0000_0002);
    set_a(1'b0, '0, 1'b0);

    // Watchdog: A opens a packet and goes silent; B waits
    set_a(1'b1, 35'h0_0000_0A10, 1'b0);
    cyc();
    chk("wd_grant0", bus.o_grant, 2'b01);
    set_a(1'b0, '0, 1'b0);
    set_b(1'b1, 35'h0_0000_0B10, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      cyc();
      chk($sformatf("wd_grant%0d", k), bus.o_grant, 2'b01);
      chk($sformatf("wd_err%0d", k), bus.o_stall_err, 1'b0);
      chk($sformatf("wd_b_busy%0d", k), bus.o_b_busy, 1'b1);
    end
    cyc();
    chk("wd_fire_grant", bus.o_grant, 2'b00);
    chk("wd_fire_err", bus.o_stall_err, 1'b1);
    chk("wd_b_free", bus.o_b_busy, 1'b0);
    cyc();
    chk("wd_b_word", bus.o_word, 35'h0_0000_0B10);
    chk("wd_err_clr", bus.o_stall_err, 1'b0);

    // Asynchronous reset in the middle of a B packet with a word on the output
    set_b(1'b1, 35'h0_0000_0B20, 1'b0);
    cyc();
    chk("ar_grant_b", bus.o_grant, 2'b10);
    chk("ar_stb_pre", bus.o_stb, 1'b1);
    set_b(1'b0, '0, 1'b0);
    bus.i_busy = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_stb", bus.o_stb, 1'b0);
    chk("ar_grant", bus.o_grant, 2'b00);
    chk("ar_word", bus.o_word, 35'h0);
    cyc();
    rst_n = 1'b1;
    bus.i_busy = 1'b0;
    set_a(1'b1, 35'h0_0000_0A30, 1'b1);
    set_b(1'b1, 35'h0_0000_0B30, 1'b1);
    cyc();
    chk("ar_tie_a", bus.o_word, 35'h0_0000_0A30);
    set_a(1'b0, '0, 1'b0);
    set_b(1'b0, '0, 1'b0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
